accum_writeback_buffer: RTL and testbench
=========================================

Name: accum_writeback_buffer

Overview:
- Sits directly downstream of the core datapath. Captures each write-back beat (we, count, degree) into a small FIFO of {addr, data} entries.
- Loops the most recent written value back to the core's accumulator input.
- Drains the queued entries to the host over a valid/ready port.
- On the core's halt it flushes the FIFO, then signals done.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..32
- AW, 6, address width; matches the core's count field
- DW, 8, data width; matches degree/accumulator width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  core write strobe (core's we)
- wr_addr  in  AW  core step index (core's count)
- wr_data  in  DW  core result (core's degree)
- halt_in  in  1  core halt flag; level, sampled each cycle
- acc_out  out  DW  loop-back value to the core accumulator input
- out_valid  out  1  head entry available
- out_ready  in  1  host accepts head entry
- out_addr  out  AW  head entry address
- out_data  out  DW  head entry data
- full  out  1  FIFO holds DEPTH entries
- overflow  out  1  sticky: a write was dropped
- done  out  1  drain complete after halt

Behaviour:
- Reset (async, rst_n low): pointers=0, occupancy=0, acc_out=0, out_valid=0, full=0, overflow=0, done=0, FSM=RUN. FIFO storage is not reset. out_addr/out_data are don't-care while out_valid=0.
- FSM states:
  - RUN: accept writes; drain proceeds concurrently.
  - DRAIN: entered on the first cycle halt_in=1 is sampled in RUN. Writes are ignored. Drain continues.
  - DONE: entered the cycle after occupancy reaches 0 in DRAIN. done=1 and held. Exited only by reset.
- Push: in RUN with wr_en=1. Takes effect at the next edge.
  - If not full, {wr_addr, wr_data} is pushed.
  - If full and a pop occurs the same cycle, the push is still accepted; occupancy is unchanged.
  - If full and no pop, the write is dropped and overflow is set (sticky until reset).
- acc_out updates to wr_data on every write sampled in RUN, including dropped ones. Latency: 1 cycle.
- Pop: out_valid && out_ready at the edge. Head advances, occupancy decrements.
- out_valid = occupancy != 0. It is registered/derived from registered state; no combinational path from wr_en to out_valid.
- Head data is stable while out_valid=1 and out_ready=0.
- Push to an empty FIFO: out_valid rises the next cycle. No fall-through in the same cycle.
- Simultaneous push and pop on a non-empty FIFO: occupancy unchanged, ordering preserved.
- Pointers wrap modulo DEPTH. Occupancy range is 0..DEPTH (log2(DEPTH)+1 bits).
- halt_in and wr_en both high in the same RUN cycle: the write is accepted, then the FSM moves to DRAIN.
- halt_in falling after DRAIN is entered has no effect.
- halt with an empty FIFO: DRAIN lasts 1 cycle, then done=1.
- Reset mid-drain: all state clears immediately; queued entries are lost.

Test Plan:
- Reset check: hold rst_n=0 asynchronously mid-cycle -> all outputs 0 before the next edge. acc_out=0, out_valid=0.
- Ordered stream: write (addr 0..4, data 8'h10..8'h14), out_ready=1 -> out_valid first high 1 cycle after the first write. Entries emerge in order (0,8'h10)..(4,8'h14). acc_out=8'h14 after the last write.
- Backpressure/full: out_ready=0, write DEPTH+2 entries (addr 0..9, DEPTH=8) -> full=1 after 8 writes. overflow=1 after the 9th write. Draining yields exactly addr 0..7.
- Push+pop at full: with full=1, wr_en=1 and out_ready=1 together -> occupancy stays 8. overflow stays 0. The new entry appears last.
- Halt flush: 3 entries queued, halt_in=1 in the same cycle as a write of (3, 8'hAA), out_ready=1 -> 4 entries drained including (3, 8'hAA). A later wr_en=1 is ignored. done=1 one cycle after the last pop, held.
- Wrap-around: 3×DEPTH writes, interleaved with random out_ready -> data order intact across pointer wrap. No overflow while pops keep up.

Source files
------------

// File: rtl/accum_writeback_buffer.sv
// Queues core write-back beats as {addr,data} and drains them to the host over valid/ready. Halt flushes the queue, then raises done.
// Push is visible one cycle later with no fall-through. A full queue drops writes unless it pops in the same cycle, and a dropped write sets overflow.
module accum_writeback_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          halt_in,
    output logic [DW-1:0] acc_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          full,
    output logic          overflow,
    output logic          done
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic [DW-1:0]       acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [AW+DW-1:0]    mem_q [DEPTH];

    logic full_w, pop, wr_req, push;

    always_comb begin
        full_w   = (cnt_q == (PW+1)'(DEPTH));
        pop      = (cnt_q != '0) && out_ready;
        wr_req   = (state_q == S_RUN) && wr_en;
        // A full queue can still take a write when the head leaves on the same edge.
        push     = wr_req && (!full_w || pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        acc_d    = wr_req ? wr_data : acc_q;
        ovf_d    = ovf_q | (wr_req && !push);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (halt_in) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_addr, wr_data};
    end

    assign acc_out             = acc_q;
    assign out_valid           = (cnt_q != '0);
    assign {out_addr, out_data} = mem_q[rd_ptr_q];
    assign full                = full_w;
    assign overflow            = ovf_q;
    assign done                = (state_q == S_DONE);
endmodule

// File: tb/tb_accum_writeback_buffer.sv
// Directed bench for accum_writeback_buffer (DEPTH=8, AW=6, DW=8).
module tb_accum_writeback_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       halt_in = 1'b0;
    logic [7:0] acc_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_addr;
    logic [7:0] out_data;
    logic       full, overflow, done;

    int n_cmp = 0;
    int n_bad = 0;
    int npop  = 0;
    logic [13:0] expq[$];

    accum_writeback_buffer #(.DEPTH(8), .AW(6), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .halt_in(halt_in), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .full(full), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: any pop presented now is checked against the expected queue.
    task automatic tick();
        logic [13:0] e;
        if (out_valid && out_ready) begin
            npop++;
            e = (expq.size() != 0) ? expq.pop_front() : 14'bx;
            chk("pop_entry", {out_addr, out_data}, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; halt_in = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expq.delete();
        npop = 0;
    endtask

    task automatic drain(input int budget);
        wr_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && out_valid; i++) tick();
    endtask

    initial begin
        // Reset: asserted mid-cycle after some activity.
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd1; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        chk("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_acc", acc_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        do_reset();

        // Ordered stream with host always ready.
        out_ready = 1'b1;
        chk("stream_idle_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = 8'h10 + 8'(i);
            expq.push_back({6'(i), 8'h10 + 8'(i)});
            tick();
            if (i == 0) chk("stream_first_valid", out_valid, 1);
        end
        wr_en = 1'b0;
        chk("stream_acc", acc_out, 8'h14);
        drain(10);
        chk("stream_npop", npop, 5);
        chk("stream_left", expq.size(), 0);

        // Backpressure to full, then overflow.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = 8'h20 + 8'(i);
            if (i < 8) expq.push_back({6'(i), 8'h20 + 8'(i)});
            tick();
            if (i == 6) chk("bp_full_at7", full, 0);
            if (i == 7) begin
                chk("bp_full_at8", full, 1);
                chk("bp_ovf_at8", overflow, 0);
            end
            if (i == 8) chk("bp_ovf_at9", overflow, 1);
        end
        chk("bp_acc_dropped", acc_out, 8'h29);
        drain(12);
        chk("bp_npop", npop, 8);
        chk("bp_empty", out_valid, 0);
        chk("bp_ovf_sticky", overflow, 1);

        // Push and pop together while full.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = 8'h30 + 8'(i);
            expq.push_back({6'(i), 8'h30 + 8'(i)});
            tick();
        end
        chk("pp_full", full, 1);
        wr_en = 1'b1; wr_addr = 6'd8; wr_data = 8'h38; out_ready = 1'b1;
        expq.push_back({6'd8, 8'h38});
        tick();
        chk("pp_still_full", full, 1);
        chk("pp_no_ovf", overflow, 0);
        drain(12);
        chk("pp_npop", npop, 9);
        chk("pp_left", expq.size(), 0);

        // Halt flush with a write in the halt cycle.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = 8'h40 + 8'(i);
            expq.push_back({6'(i), 8'h40 + 8'(i)});
            tick();
        end
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'hAA; halt_in = 1'b1; out_ready = 1'b1;
        expq.push_back({6'd3, 8'hAA});
        tick();
        halt_in = 1'b0;
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h55;
        for (int i = 0; i < 10 && out_valid; i++) tick();
        chk("halt_npop", npop, 4);
        chk("halt_done_early", done, 0);
        chk("halt_acc_ignored", acc_out, 8'hAA);
        tick();
        chk("halt_done", done, 1);
        tick(); tick();
        chk("halt_done_held", done, 1);
        chk("halt_no_late_write", out_valid, 0);
        wr_en = 1'b0;

        // Halt on an empty queue.
        do_reset();
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk("halt_empty_drain", done, 0);
        tick();
        chk("halt_empty_done", done, 1);

        // Pointer wrap with random host readiness.
        do_reset();
        for (int n = 0; n < 24; n++) begin
            wr_en = 1'b1; wr_addr = 6'(n); wr_data = 8'h60 + 8'(n);
            expq.push_back({6'(n), 8'h60 + 8'(n)});
            out_ready = full ? 1'b1 : 1'($urandom_range(1));
            tick();
        end
        drain(20);
        chk("wrap_npop", npop, 24);
        chk("wrap_left", expq.size(), 0);
        chk("wrap_no_ovf", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
